// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter/sequencer sharing one 32x8 data memory port between a CPU
// requester (A) and a loader/debug requester (B); three cycles per access.
module data_memory_arbiter #(
  parameter int MEM_DEPTH  = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic                  a_err,
  output logic [DATA_WIDTH-1:0] a_rdata,

  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic                  b_err,
  output logic [DATA_WIDTH-1:0] b_rdata,

  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_datawrite,
  input  logic [DATA_WIDTH-1:0] mem_read_data,

  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  sel_q, sel_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  grant_b;
  logic                  oob;

  assign oob = (int'(addr_q) >= MEM_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_B;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // NOTE: the latched access carries no reset; it is only consumed in ISSUE/DONE,
  // which are reachable solely through the IDLE edge that reloads it.
  always_ff @(posedge clk) begin
    sel_q   <= sel_d;
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    sel_d         = sel_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    a_rdata_d     = a_rdata_q;
    b_rdata_d     = b_rdata_q;
    grant_b       = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    mem_address   = '0;
    mem_datawrite = '0;
    a_ack         = 1'b0;
    b_ack         = 1'b0;
    a_err         = 1'b0;
    b_err         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          // B wins when alone, or on a tie when A was served last.
          grant_b      = b_req && (!a_req || (last_grant_q == GRANT_A));
          sel_d        = grant_b;
          last_grant_d = grant_b;
          we_d         = grant_b ? b_we    : a_we;
          addr_d       = grant_b ? b_addr  : a_addr;
          wdata_d      = grant_b ? b_wdata : a_wdata;
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        mem_address   = addr_q;
        mem_datawrite = we_q ? wdata_q : '0;
        mem_write     = we_q && !oob;
        mem_read      = !we_q && !oob;
        if (!we_q) begin
          if (sel_q == GRANT_B) b_rdata_d = oob ? '0 : mem_read_data;
          else                  a_rdata_d = oob ? '0 : mem_read_data;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        // A reset landing in DONE suppresses the completion pulse.
        a_ack   = (sel_q == GRANT_A) && !reset;
        b_ack   = (sel_q == GRANT_B) && !reset;
        a_err   = a_ack && oob;
        b_err   = b_ack && oob;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: directed accesses push expected acks
// and memory strobes; a negedge monitor pops and compares them.
module tb_data_memory_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_ack, a_err, b_ack, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_write, mem_read;
  logic [7:0] mem_address, mem_datawrite, mem_read_data;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       who;
    logic       err;
    logic [7:0] ra;
    logic [7:0] rb;
  } ack_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } strobe_t;

  ack_t    ack_q[$];
  strobe_t stb_q[$];
  ack_t    mon_a;
  strobe_t mon_s;

  logic [7:0] mem [32] = '{default: 8'h00};

  always #5 clk = ~clk;

  data_memory_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_ack        (a_ack),
    .a_err        (a_err),
    .a_rdata      (a_rdata),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_ack        (b_ack),
    .b_err        (b_err),
    .b_rdata      (b_rdata),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_datawrite(mem_datawrite),
    .mem_read_data(mem_read_data),
    .busy         (busy)
  );

  // Behavioural 32x8 memory with combinational read.
  assign mem_read_data = (mem_address < 8'd32) ? mem[mem_address[4:0]] : 8'h00;
  always @(posedge clk) begin
    if (mem_write && mem_address < 8'd32) mem[mem_address[4:0]] <= mem_datawrite;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT acks or strobes the memory.
  always @(negedge clk) begin
    if (a_ack || b_ack) begin
      check("single_ack", 32'(a_ack && b_ack), 32'd0);
      if (ack_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b, expected no ack (t=%0t)", a_ack, b_ack, $time);
      end else begin
        mon_a = ack_q.pop_front();
        check("ack_who",   32'(b_ack), 32'(mon_a.who));
        check("ack_err",   32'(mon_a.who ? b_err : a_err), 32'(mon_a.err));
        check("err_loser", 32'(mon_a.who ? a_err : b_err), 32'd0);
        check("a_rdata",   32'(a_rdata), 32'(mon_a.ra));
        check("b_rdata",   32'(b_rdata), 32'(mon_a.rb));
      end
    end
    if (mem_write || mem_read) begin
      check("strobe_excl", 32'(mem_write && mem_read), 32'd0);
      if (stb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: we=%0b re=%0b addr=0x%0h, expected no strobe (t=%0t)",
                 mem_write, mem_read, mem_address, $time);
      end else begin
        mon_s = stb_q.pop_front();
        check("mem_write",     32'(mem_write),     32'(mon_s.we));
        check("mem_address",   32'(mem_address),   32'(mon_s.addr));
        check("mem_datawrite", 32'(mem_datawrite), 32'(mon_s.data));
      end
    end
  end

  // One isolated access from IDLE; expected rdata values are for both requesters.
  task automatic access(input logic who, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic err,
                        input logic [7:0] ra, input logic [7:0] rb);
    int cnt;
    ack_q.push_back(ack_t'{who, err, ra, rb});
    if (!err) stb_q.push_back(strobe_t'{we, addr, we ? wdata : 8'h00});
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
    if (who) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      check("busy_active", 32'(busy), 32'd1);
    end while (!(who ? b_ack : a_ack) && cnt < 10);
    check("ack_latency", 32'(cnt), 32'd2);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_acks",     32'({a_ack, a_err, b_ack, b_err}), 32'd0);
    check("rst_a_rdata",  32'(a_rdata), 32'd0);
    check("rst_b_rdata",  32'(b_rdata), 32'd0);
    check("rst_mem",      32'({mem_write, mem_read, mem_address, mem_datawrite}), 32'd0);
    reset = 1'b0;

    // Basic write then read-back by A; B seeds two locations.
    access(1'b0, 1'b1, 8'd3, 8'hA5, 1'b0, 8'h00, 8'h00);
    access(1'b0, 1'b0, 8'd3, 8'h00, 1'b0, 8'hA5, 8'h00);
    access(1'b1, 1'b1, 8'd1, 8'h11, 1'b0, 8'hA5, 8'h00);
    access(1'b1, 1'b1, 8'd2, 8'h22, 1'b0, 8'hA5, 8'h00);

    // Both requesting continuously; last grant was B so A leads.
    ack_q.push_back(ack_t'{1'b0, 1'b0, 8'h11, 8'h00});
    ack_q.push_back(ack_t'{1'b1, 1'b0, 8'h11, 8'h22});
    ack_q.push_back(ack_t'{1'b0, 1'b0, 8'h11, 8'h22});
    ack_q.push_back(ack_t'{1'b1, 1'b0, 8'h11, 8'h22});
    for (int k = 0; k < 4; k++) stb_q.push_back(strobe_t'{1'b0, (k % 2 == 0) ? 8'd1 : 8'd2, 8'h00});
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'd2;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!(a_ack || b_ack) && cnt < 10);
      if (k == 0) check("tie_latency", 32'(cnt), 32'd2);
      else        check("ack_spacing", 32'(cnt), 32'd3);
    end
    a_req = 1'b0;
    b_req = 1'b0;

    // Out-of-range read and write by B.
    access(1'b1, 1'b0, 8'd32,  8'h00, 1'b1, 8'h11, 8'h00);
    access(1'b1, 1'b1, 8'hFF,  8'h77, 1'b1, 8'h11, 8'h00);

    // Reset during ISSUE of an A write: no ack, back to IDLE.
    stb_q.push_back(strobe_t'{1'b1, 8'd7, 8'h5A});
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'd7; a_wdata = 8'h5A;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    a_req = 1'b0;
    @(negedge clk);
    check("rst_mid_busy",  32'(busy), 32'd0);
    check("rst_mid_mem",   32'({mem_write, mem_read, mem_address}), 32'd0);
    check("rst_mid_ack",   32'(a_ack), 32'd0);
    check("rst_mid_rdata", 32'(a_rdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_ack", 32'(a_ack), 32'd0);
    access(1'b0, 1'b0, 8'd3, 8'h00, 1'b0, 8'hA5, 8'h00);

    // B holds its request for 9 cycles: acks at 2, 5, 8.
    for (int k = 0; k < 3; k++) begin
      ack_q.push_back(ack_t'{1'b1, 1'b0, 8'hA5, 8'h11});
      stb_q.push_back(strobe_t'{1'b0, 8'd1, 8'h00});
    end
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'd1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check("hold_ack", 32'(b_ack), 32'(i == 2 || i == 5 || i == 8));
    end
    b_req = 1'b0;
    repeat (6) @(negedge clk);
    check("hold_idle",     32'(busy), 32'd0);
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);
    check("stb_q_drained", 32'(stb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
